morse_hex_transmitter: RTL and testbench

//  Morse keyer: latches one 4-bit hex digit (0-9, A-F) and emits its International Morse

---
 rtl/morse_hex_transmitter.sv | 145 ++++++++++++++
 tb/tb_morse_hex_transmitter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_hex_transmitter.sv
// Morse keyer: latches one hex digit and keys its International Morse code
// as timed marks and spaces, followed by a 3-unit inter-character gap.
module morse_hex_transmitter #(
    parameter int unsigned UNIT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] digit,
    output logic       key_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_q;
    logic [1:0]      unit_q;
    logic [1:0]      unit_last;
    logic [2:0]      len_q;
    logic [4:0]      pat_q;
    logic            unit_tick;
    logic            sym_end;
    logic            accept;
    logic            key_d, busy_d, done_d;
    logic [7:0]      code;

    // {len[2:0], pat[4:0]}: element count and left-justified pattern, 1 = dash.
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'h0:    c = {3'd5, 5'b11111};
            4'h1:    c = {3'd5, 5'b01111};
            4'h2:    c = {3'd5, 5'b00111};
            4'h3:    c = {3'd5, 5'b00011};
            4'h4:    c = {3'd5, 5'b00001};
            4'h5:    c = {3'd5, 5'b00000};
            4'h6:    c = {3'd5, 5'b10000};
            4'h7:    c = {3'd5, 5'b11000};
            4'h8:    c = {3'd5, 5'b11100};
            4'h9:    c = {3'd5, 5'b11110};
            4'hA:    c = {3'd2, 5'b01000};
            4'hB:    c = {3'd4, 5'b10000};
            4'hC:    c = {3'd4, 5'b10100};
            4'hD:    c = {3'd3, 5'b10000};
            4'hE:    c = {3'd1, 5'b00000};
            default: c = {3'd4, 5'b00100};
        endcase
        return c;
    endfunction

    assign code      = encode(digit);
    assign unit_tick = (cyc_q == CYC_LAST);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case can leave a value held and infer a latch.
        unit_last = 2'd0;
        case (state_q)
            MARK:    unit_last = pat_q[4] ? 2'd2 : 2'd0;
            GAP:     unit_last = 2'd2;
            default: unit_last = 2'd0;
        endcase
    end

    assign sym_end = (state_q != IDLE) && unit_tick && (unit_q == unit_last);

    // The edge that closes the gap also accepts a waiting start, so held
    // start yields back-to-back digits separated by exactly the 3U gap.
    assign accept = start && ((state_q == IDLE) || ((state_q == GAP) && sym_end));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MARK;
            MARK:    if (sym_end) state_d = (len_q == 3'd1) ? GAP : SPACE;
            SPACE:   if (sym_end) state_d = MARK;
            GAP:     if (sym_end) state_d = accept ? MARK : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_d  = (state_d == MARK);
        busy_d = (state_d != IDLE);
        done_d = (state_q == GAP) && sym_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            key_out <= key_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Unit/element timing and the shifting symbol store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= '0;
            unit_q <= '0;
            len_q  <= '0;
            pat_q  <= '0;
        end else if (accept) begin
            cyc_q  <= '0;
            unit_q <= '0;
            len_q  <= code[7:5];
            pat_q  <= code[4:0];
        end else if (state_q != IDLE) begin
            cyc_q <= unit_tick ? '0 : cyc_q + CW'(1);
            if (sym_end)
                unit_q <= '0;
            else if (unit_tick)
                unit_q <= unit_q + 2'd1;
            if ((state_q == MARK) && sym_end) begin
                len_q <= len_q - 3'd1;
                pat_q <= pat_q << 1;
            end
        end
    end

endmodule

// File: tb/tb_morse_hex_transmitter.sv
// Bench for morse_hex_transmitter: expected key waveforms are expanded from
// the dot/dash code strings and compared cycle by cycle (U=4 and U=1 instances).
module tb_morse_hex_transmitter;

    localparam int U0 = 4;
    localparam int U1 = 1;

    logic       clk = 1'b0;
    logic       rst_n_v [2];
    logic       start_v [2];
    logic [3:0] digit_v [2];
    logic       key_v   [2];
    logic       busy_v  [2];
    logic       done_v  [2];

    always #5 clk = ~clk;

    morse_hex_transmitter #(.UNIT_CYCLES(U0)) dut0 (
        .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]), .digit(digit_v[0]),
        .key_out(key_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    morse_hex_transmitter #(.UNIT_CYCLES(U1)) dut1 (
        .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]), .digit(digit_v[1]),
        .key_out(key_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    string code_tbl [16] = '{"-----", ".----", "..---", "...--", "....-", ".....",
                             "-....", "--...", "---..", "----.", ".-", "-...",
                             "-.-.", "-..", ".", "..-."};

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expand a code string into the per-cycle key level expected while busy.
    task automatic build(input int d, input int u);
        string s;
        s = code_tbl[d];
        exp_q.delete();
        for (int k = 0; k < s.len(); k++) begin
            int w;
            w = (s[k] == "-") ? 3 * u : u;
            repeat (w) exp_q.push_back(1'b1);
            if (k != s.len() - 1) repeat (u) exp_q.push_back(1'b0);
        end
        repeat (3 * u) exp_q.push_back(1'b0);
    endtask

    function automatic int code_bits(input int d);
        string s;
        int b;
        s = code_tbl[d];
        b = 0;
        for (int k = 0; k < s.len(); k++) b = (b << 1) | ((s[k] == "-") ? 1 : 0);
        return b;
    endfunction

    // Called at a negedge; raises start there and checks the whole transmission
    // up to and including the done sample. noise fires ignored starts while busy.
    task automatic send(input int sel, input logic [3:0] d, input bit noise);
        int u, n, run, dec_len, dec_bits, busy_cnt;
        string s;
        u = sel ? U1 : U0;
        s = code_tbl[d];
        build(d, u);
        n = exp_q.size();
        run = 0; dec_len = 0; dec_bits = 0; busy_cnt = 0;
        start_v[sel] = 1'b1;
        digit_v[sel] = d;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("key u%0d d%0h i%0d", u, d, i), key_v[sel], exp_q[i]);
            check($sformatf("busy u%0d d%0h i%0d", u, d, i), busy_v[sel], 1);
            check($sformatf("done_low u%0d d%0h i%0d", u, d, i), done_v[sel], 0);
            if (busy_v[sel] === 1'b1) busy_cnt++;
            if (key_v[sel] === 1'b1) begin
                run++;
            end else if (run > 0) begin
                check($sformatf("pulse_width d%0h", d), ((run == u) || (run == 3 * u)), 1);
                dec_bits = (dec_bits << 1) | ((run == 3 * u) ? 1 : 0);
                dec_len++;
                run = 0;
            end
            if (noise && (i < n - 1)) begin
                start_v[sel] = 1'($urandom_range(0, 1));
                digit_v[sel] = 4'($urandom);
            end else begin
                start_v[sel] = 1'b0;
            end
        end
        @(negedge clk);
        check($sformatf("done_pulse u%0d d%0h", u, d), done_v[sel], 1);
        check($sformatf("busy_end u%0d d%0h", u, d), busy_v[sel], 0);
        check($sformatf("key_end u%0d d%0h", u, d), key_v[sel], 0);
        check($sformatf("busy_len u%0d d%0h", u, d), busy_cnt, n);
        check($sformatf("decode_len d%0h", d), dec_len, s.len());
        check($sformatf("decode_pat d%0h", d), dec_bits, code_bits(d));
    endtask

    task automatic idle(input int sel, input int k);
        for (int j = 0; j < k; j++) begin
            @(negedge clk);
            check($sformatf("idle_busy u%0d", sel), busy_v[sel], 0);
            check($sformatf("idle_key u%0d", sel), key_v[sel], 0);
            check($sformatf("idle_done u%0d", sel), done_v[sel], 0);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_n_v[s] = 1'b0;
            start_v[s] = 1'b0;
            digit_v[s] = 4'h0;
        end
        #1;
        for (int s = 0; s < 2; s++) begin
            check("reset_key", key_v[s], 0);
            check("reset_busy", busy_v[s], 0);
            check("reset_done", done_v[s], 0);
        end
        repeat (2) @(negedge clk);
        rst_n_v[0] = 1'b1;
        rst_n_v[1] = 1'b1;
        idle(0, 2);

        // Single digits E, A, 0, 5.
        send(0, 4'hE, 1'b0);
        idle(0, 2);
        send(0, 4'hA, 1'b0);
        idle(0, 1);
        send(0, 4'h0, 1'b0);
        idle(0, 1);
        send(0, 4'h5, 1'b0);
        idle(0, 1);

        // Sweep all digits; each start lands on the previous done cycle.
        for (int d = 0; d < 16; d++) send(0, 4'(d), 1'b0);
        idle(0, 1);

        // Ignored starts with changing digits during a transmission.
        send(0, 4'h3, 1'b1);
        idle(0, 1);

        // start held high with E: a mark and a done pulse every 16 clk.
        start_v[0] = 1'b1;
        digit_v[0] = 4'hE;
        for (int j = 0; j < 48; j++) begin
            @(negedge clk);
            check($sformatf("held_key j%0d", j), key_v[0], ((j % 16) < 4) ? 1 : 0);
            check($sformatf("held_busy j%0d", j), busy_v[0], 1);
            check($sformatf("held_done j%0d", j), done_v[0], ((j % 16 == 0) && (j > 0)) ? 1 : 0);
            if (j == 47) start_v[0] = 1'b0;
        end
        @(negedge clk);
        check("held_final_done", done_v[0], 1);
        check("held_final_busy", busy_v[0], 0);
        idle(0, 1);

        // Randomized digits, noise and idle spacing.
        repeat (20) begin
            send(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            idle(0, $urandom_range(0, 2));
        end
        idle(0, 1);

        // Asynchronous reset in the middle of the first dash of 7.
        start_v[0] = 1'b1;
        digit_v[0] = 4'h7;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_key", key_v[0], 1);
        #2 rst_n_v[0] = 1'b0;
        #1;
        check("async_reset_key", key_v[0], 0);
        check("async_reset_busy", busy_v[0], 0);
        check("async_reset_done", done_v[0], 0);
        @(negedge clk);
        rst_n_v[0] = 1'b1;
        idle(0, 2);
        send(0, 4'hE, 1'b0);
        idle(0, 1);

        // U=1: E keeps busy high for 4 clk, then random traffic.
        send(1, 4'hE, 1'b0);
        idle(1, 1);
        repeat (8) begin
            send(1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            idle(1, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
